// File: rtl/square_animator_if.sv
// Drawer-side handshake: start/origin/colour towards square_drawer, done pulse back.
interface square_animator_if;
    logic        draw_start;
    logic [10:0] x0;
    logic [10:0] y0;
    logic        colour;
    logic        draw_done;

    modport master (
        output draw_start,
        output x0,
        output y0,
        output colour,
        input  draw_done
    );

    modport slave (
        input  draw_start,
        input  x0,
        input  y0,
        input  colour,
        output draw_done
    );
endinterface

// File: rtl/square_animator.sv
// Bouncing-square sequencer: once per frame tick it erases the square, steps it with
// edge reflection and redraws it through the square_drawer start/done handshake.
module square_animator #(
    parameter int SIZE        = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TICK_CYCLES = 1_000_000,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic busy,
    square_animator_if.master bus
);

    localparam logic [10:0] XMAX = 11'(SCREEN_W - 1 - SIZE);
    localparam logic [10:0] YMAX = 11'(SCREEN_H - 1 - SIZE);
    localparam int          TW   = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    localparam logic [2:0] INIT        = 3'd0;
    localparam logic [2:0] DRAW_ISSUE  = 3'd1;
    localparam logic [2:0] DRAW_WAIT   = 3'd2;
    localparam logic [2:0] GAP         = 3'd3;
    localparam logic [2:0] HOLD        = 3'd4;
    localparam logic [2:0] ERASE_ISSUE = 3'd5;
    localparam logic [2:0] ERASE_WAIT  = 3'd6;
    localparam logic [2:0] MOVE        = 3'd7;

    logic [2:0]    state_q,    state_d;
    logic          settle_q,   settle_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          pending_q,  pending_d;
    logic          dx_q,       dx_d;
    logic          dy_q,       dy_d;
    logic [10:0]   x_q,        x_d;
    logic [10:0]   y_q,        y_d;
    logic          colour_q,   colour_d;
    logic          tick;
    logic          hold_go;

    // One reflecting step along an axis; returns {dir, pos}. A zero-length axis is frozen.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                              input logic [10:0] max);
        if (max == 11'd0)
            return {dir, pos};
        else if (dir && pos == max)
            return {1'b0, max - 11'd1};
        else if (!dir && pos == 11'd0)
            return {1'b1, 11'd1};
        else if (dir)
            return {1'b1, pos + 11'd1};
        else
            return {1'b0, pos - 11'd1};
    endfunction

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;

        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        hold_go    = (state_q == HOLD) && enable && (tick || pending_q);

        // A tick taken by HOLD is consumed; any other tick only arms the single-deep pending flag.
        if (hold_go)
            pending_d = 1'b0;
        else if (tick)
            pending_d = 1'b1;
        else
            pending_d = pending_q;

        case (state_q)
            INIT: begin
                if (settle_q) begin
                    settle_d = 1'b0;
                    colour_d = 1'b1;
                    state_d  = DRAW_ISSUE;
                end else begin
                    settle_d = 1'b1;
                end
            end
            DRAW_ISSUE:  state_d = DRAW_WAIT;
            ERASE_ISSUE: state_d = ERASE_WAIT;
            DRAW_WAIT, ERASE_WAIT: begin
                if (bus.draw_done) begin
                    settle_d = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (settle_q) begin
                    settle_d = 1'b0;
                    state_d  = colour_q ? HOLD : MOVE;
                end else begin
                    settle_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_go) begin
                    colour_d = 1'b0;
                    state_d  = ERASE_ISSUE;
                end
            end
            MOVE: begin
                {dx_d, x_d} = step_axis(x_q, dx_q, XMAX);
                {dy_d, y_d} = step_axis(y_q, dy_q, YMAX);
                colour_d    = 1'b1;
                state_d     = DRAW_ISSUE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            settle_q   <= 1'b0;
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            x_q        <= 11'(X_INIT);
            y_q        <= 11'(Y_INIT);
            colour_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
        end
    end

    assign bus.draw_start = (state_q == DRAW_ISSUE) || (state_q == ERASE_ISSUE);
    assign bus.x0         = x_q;
    assign bus.y0         = y_q;
    assign bus.colour     = colour_q;
    assign busy           = (state_q != HOLD);

endmodule

// File: tb/tb_square_animator.sv
// Bench for square_animator: drawer models answer each start after 9 cycles and a
// scoreboard of expected passes (x0, y0, colour) is checked on every draw_start.
module tb_square_animator;

    localparam int SIZE = 2;
    localparam int SW   = 8;
    localparam int SH   = 6;
    localparam int TA   = 50;
    localparam int TB   = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pass_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic enable_a = 1'b1;
    logic enable_b = 1'b1;
    logic stray_a = 1'b0;
    logic busy_a, busy_b;
    logic [8:0] sr_a, sr_b;

    square_animator_if bus_a();
    square_animator_if bus_b();

    square_animator #(.SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH), .TICK_CYCLES(TA),
                      .X_INIT(0), .Y_INIT(0)) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .busy(busy_a), .bus(bus_a));

    square_animator #(.SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH), .TICK_CYCLES(TB),
                      .X_INIT(0), .Y_INIT(0)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .busy(busy_b), .bus(bus_b));

    // Drawer models: done pulses 9 cycles after start; they share the animator's reset.
    always @(posedge clk) begin
        if (reset_a) sr_a <= '0;
        else         sr_a <= {sr_a[7:0], bus_a.draw_start};
        if (reset_b) sr_b <= '0;
        else         sr_b <= {sr_b[7:0], bus_b.draw_start};
    end
    assign bus_a.draw_done = sr_a[8] | stray_a;
    assign bus_b.draw_done = sr_b[8];

    // Independent model of the frame-tick phase of dut_a.
    int tcnt_a = 0;
    int ticks_a = 0;
    always @(posedge clk) begin
        if (reset_a) begin
            tcnt_a <= 0;
        end else begin
            tcnt_a <= (tcnt_a == TA - 1) ? 0 : tcnt_a + 1;
            if (tcnt_a == TA - 1) ticks_a <= ticks_a + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int starts_a = 0;
    pass_t qa[$];
    pass_t qb[$];
    int xs [0:13] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3};
    int ys [0:13] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};

    function automatic pass_t mk(input int x, input int y, input logic c);
        pass_t p;
        p.x = 11'(x);
        p.y = 11'(y);
        p.c = c;
        return p;
    endfunction

    // Scoreboard for dut_a: every start must match the next expected pass and never repeat back-to-back.
    initial begin
        pass_t e;
        logic  prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.draw_start === 1'b1) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL sb_a_unexpected_pass got x0=%0d y0=%0d colour=%0d, required no pass",
                             bus_a.x0, bus_a.y0, bus_a.colour);
                end else begin
                    e = qa.pop_front();
                    if ({prev, bus_a.x0, bus_a.y0, bus_a.colour} !== {1'b0, e}) begin
                        failures++;
                        $display("FAIL sb_a_pass got x0=%0d y0=%0d colour=%0d prev_start=%0b, required x0=%0d y0=%0d colour=%0d prev_start=0",
                                 bus_a.x0, bus_a.y0, bus_a.colour, prev, e.x, e.y, e.c);
                    end
                end
                starts_a++;
            end
            prev = bus_a.draw_start;
        end
    end

    // Scoreboard for dut_b, plus HOLD must last exactly one cycle when a tick is pending.
    initial begin
        pass_t e;
        logic  prev = 1'b0;
        int    lowrun = 0;
        forever begin
            @(negedge clk);
            if (bus_b.draw_start === 1'b1) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_b_unexpected_pass got x0=%0d y0=%0d colour=%0d, required no pass",
                             bus_b.x0, bus_b.y0, bus_b.colour);
                end else begin
                    e = qb.pop_front();
                    if ({prev, bus_b.x0, bus_b.y0, bus_b.colour} !== {1'b0, e}) begin
                        failures++;
                        $display("FAIL sb_b_pass got x0=%0d y0=%0d colour=%0d prev_start=%0b, required x0=%0d y0=%0d colour=%0d prev_start=0",
                                 bus_b.x0, bus_b.y0, bus_b.colour, prev, e.x, e.y, e.c);
                    end
                end
            end
            prev = bus_b.draw_start;
            if (reset_b) begin
                lowrun = 0;
            end else if (busy_b === 1'b0) begin
                lowrun++;
            end else if (lowrun > 0) begin
                checks++;
                if (lowrun !== 1) begin
                    failures++;
                    $display("FAIL pending_hold_cycles got %0d, required 1", lowrun);
                end
                lowrun = 0;
            end
        end
    end

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (busy_a !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle got busy=%0b, required 0", name, busy_a);
        end
    endtask

    task automatic test_reset;
        reset_a  = 1'b1;
        enable_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.draw_start, bus_a.x0, bus_a.y0, bus_a.colour, busy_a} !==
            {1'b0, 11'd0, 11'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got start=%0b x0=%0d y0=%0d colour=%0b busy=%0b, required 0 0 0 0 1",
                     bus_a.draw_start, bus_a.x0, bus_a.y0, bus_a.colour, busy_a);
        end
        qa.push_back(mk(0, 0, 1'b1));
        @(negedge clk);
        reset_a = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.draw_start !== 1'b0) begin
            failures++;
            $display("FAIL first_start_early got start=%0b, required 0", bus_a.draw_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.draw_start !== 1'b1) begin
            failures++;
            $display("FAIL first_start_cycle3 got start=%0b, required 1", bus_a.draw_start);
        end
        wait_idle_a("first_draw");
    endtask

    task automatic test_move_latency;
        int n = 0;
        qa.push_back(mk(0, 0, 1'b0));
        qa.push_back(mk(1, 1, 1'b1));
        while (busy_a === 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({busy_a, bus_a.draw_start} !== 2'b11) begin
            failures++;
            $display("FAIL hold_exit got busy=%0b start=%0b, required busy=1 start=1",
                     busy_a, bus_a.draw_start);
        end
        n = 0;
        while (bus_a.draw_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_a.draw_start !== 1'b1 && n < 10);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL done_to_draw_latency got %0d cycles, required 4", n);
        end
        wait_idle_a("move");
    endtask

    task automatic test_bounce;
        int n = 0;
        for (int k = 2; k <= 12; k++) begin
            qa.push_back(mk(xs[k-1], ys[k-1], 1'b0));
            qa.push_back(mk(xs[k], ys[k], 1'b1));
        end
        while (qa.size() != 0 && n < 800) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qa.size() !== 0) begin
            failures++;
            $display("FAIL bounce_passes got %0d passes outstanding, required 0", qa.size());
        end
        wait_idle_a("bounce");
        checks++;
        if ({bus_a.x0, bus_a.y0, bus_a.colour} !== {11'd2, 11'd0, 1'b1}) begin
            failures++;
            $display("FAIL bounce_final got x0=%0d y0=%0d colour=%0b, required 2 0 1",
                     bus_a.x0, bus_a.y0, bus_a.colour);
        end
    endtask

    task automatic test_enable;
        int n = 0;
        int s0;
        int t0;
        enable_a = 1'b0;
        s0 = starts_a;
        t0 = ticks_a;
        while (((ticks_a - t0) < 3 || tcnt_a != 5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((starts_a - s0) !== 0 || (ticks_a - t0) < 3) begin
            failures++;
            $display("FAIL enable_low got %0d starts over %0d ticks, required 0 starts over 3 ticks",
                     starts_a - s0, ticks_a - t0);
        end
        qa.push_back(mk(2, 0, 1'b0));
        qa.push_back(mk(3, 1, 1'b1));
        s0 = starts_a;
        enable_a = 1'b1;
        n = 0;
        while (tcnt_a != 45 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((starts_a - s0) !== 2) begin
            failures++;
            $display("FAIL enable_resume_starts got %0d, required 2", starts_a - s0);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL enable_resume_idle got busy=%0b, required 0", busy_a);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int s0;
        qa.push_back(mk(3, 1, 1'b0));
        qa.push_back(mk(4, 2, 1'b1));
        while (qa.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus_a.draw_start, bus_a.x0, bus_a.y0, bus_a.colour, busy_a} !==
            {1'b0, 11'd0, 11'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset got start=%0b x0=%0d y0=%0d colour=%0b busy=%0b, required 0 0 0 0 1",
                     bus_a.draw_start, bus_a.x0, bus_a.y0, bus_a.colour, busy_a);
        end
        @(negedge clk);
        reset_a = 1'b0;
        qa.push_back(mk(0, 0, 1'b1));
        stray_a = 1'b1;
        @(negedge clk);
        stray_a = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.draw_start !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_restart got start=%0b, required 1", bus_a.draw_start);
        end
        wait_idle_a("mid_reset");
        enable_a = 1'b0;
        s0 = starts_a;
        stray_a = 1'b1;
        @(negedge clk);
        stray_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || (starts_a - s0) !== 0) begin
            failures++;
            $display("FAIL stray_done_hold got busy=%0b starts=%0d, required busy=0 starts=0",
                     busy_a, starts_a - s0);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        qb.push_back(mk(0, 0, 1'b1));
        for (int k = 1; k <= 7; k++) begin
            qb.push_back(mk(xs[k-1], ys[k-1], 1'b0));
            qb.push_back(mk(xs[k], ys[k], 1'b1));
        end
        @(negedge clk);
        reset_b = 1'b0;
        while (qb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        reset_b = 1'b1;
        checks++;
        if (qb.size() !== 0) begin
            failures++;
            $display("FAIL back_to_back_passes got %0d outstanding, required 0", qb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_move_latency();
        test_bounce();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
